gf2m_reduce_seq: RTL and testbench



---
 rtl/gf2m_pkg.sv | 16 +
 rtl/gf2m_reduce_step.sv | 35 +++
 rtl/gf2m_reduce_seq.sv | 121 ++++++++++++
 tb/tb_gf2m_reduce_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared defaults and FSM state type for the GF(2^M) reducer.
// Field degree M, product width N = 2*M-1 and the irreducible polynomial
// x^5 + x^2 + 1 are the datapath defaults.
package gf2m_pkg;

  localparam int M_DEF = 5;
  localparam int N_DEF = 2 * M_DEF - 1;
  localparam logic [M_DEF:0] POLY_DEF = 6'b100101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RED  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf2m_reduce_step.sv
// gf2m_reduce_step: one combinational reduction step. If bit cnt of r is set,
// r is XORed with POLY aligned so that its leading term cancels bit cnt.
// Each legal cnt value (M..N-1) gets its own constant-shift candidate, so no
// barrel shifter is needed; at most one candidate is selected.
module gf2m_reduce_step
  import gf2m_pkg::*;
#(
  parameter int            M    = M_DEF,
  parameter int            N    = N_DEF,
  parameter logic [M:0]    POLY = POLY_DEF,
  parameter int            CW   = $clog2(N)
) (
  input  logic [N-1:0]  r,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  r_next
);

  // XOR chain: stage gi folds in POLY<<gi when cnt selects bit M+gi and it is set
  logic [N-1:0] chain [0:N-M];

  assign chain[0] = r;

  for (genvar gi = 0; gi < N - M; gi++) begin : g_stage
    localparam int B = M + gi;
    logic         hit;
    logic [N-1:0] poly_at;

    assign poly_at      = N'(POLY) << gi;
    assign hit          = (cnt == CW'(B)) && r[B];
    assign chain[gi+1]  = chain[gi] ^ ({N{hit}} & poly_at);
  end

  assign r_next = chain[N-M];

endmodule

// File: rtl/gf2m_reduce_seq.sv
// gf2m_reduce_seq: sequential polynomial-basis reducer. Takes a (2M-1)-bit
// carry-less product and reduces one high-order bit per cycle, N-M cycles per
// product, with valid/ready on both sides.
// Optional build macro GF_ACC_EN adds an output accumulator (acc_clr port,
// out_data = acc ^ remainder, acc updated on every output handshake).
module gf2m_reduce_seq
  import gf2m_pkg::*;
#(
  parameter int          M    = M_DEF,
  parameter int          N    = N_DEF,
  parameter logic [M:0]  POLY = POLY_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef GF_ACC_EN
  input  logic         acc_clr,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data
);

  localparam int CW = $clog2(N);

  // Reject non-monic polynomials and product widths that do not match M
  if (POLY[M] !== 1'b1 || N != 2 * M - 1) begin : g_param_check
    $error("gf2m_reduce_seq: POLY[M] must be 1 and N must equal 2*M-1");
  end

  state_t        state_reg;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  r_next;
  logic [CW-1:0] cnt_reg;
  logic          out_valid_reg;
  logic          in_accept;

  // Ready depends only on state and the downstream ready, never on in_valid
  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign in_accept = in_valid && in_ready;
  assign out_valid = out_valid_reg;

  gf2m_reduce_step #(
    .M    (M),
    .N    (N),
    .POLY (POLY),
    .CW   (CW)
  ) u_step (
    .r      (r_reg),
    .cnt    (cnt_reg),
    .r_next (r_next)
  );

  // Control FSM: load, fixed-length reduction, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_accept) begin
            r_reg     <= in_data;
            cnt_reg   <= CW'(N - 1);
            state_reg <= RED;
          end
        end
        RED: begin
          r_reg <= r_next;
          if (cnt_reg == CW'(M)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (in_valid) begin
              // Same-cycle hand-off: next product starts while this one leaves
              r_reg     <= in_data;
              cnt_reg   <= CW'(N - 1);
              state_reg <= RED;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef GF_ACC_EN
  logic [M-1:0] acc_reg;

  // Accumulator: captures each delivered result; a clear overrides a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (acc_clr) begin
      acc_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      acc_reg <= out_data;
    end
  end

  assign out_data = acc_reg ^ r_reg[M-1:0];
`else
  assign out_data = r_reg[M-1:0];
`endif

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// tb_gf2m_reduce_seq: directed bench for gf2m_reduce_seq at default
// parameters (M=5, N=9, POLY=x^5+x^2+1). Expected values are hand-reduced.
// Build with GF_ACC_EN defined to also exercise the accumulator.
module tb_gf2m_reduce_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
`ifdef GF_ACC_EN
  logic       acc_clr;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  gf2m_reduce_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef GF_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one product at a negedge; returns 1 ns after the accepting edge
  task automatic send(input logic [8:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    chk("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 9'($urandom);
  endtask

  // Count edges until out_valid rises, bounded at 20
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Full transaction with out_ready=1: latency, data, then out_valid drops
  task automatic xact(input string tag, input logic [8:0] d, input logic [4:0] exp);
    send(d);
    wait_out(lat);
    chk({tag, "_latency"}, 16'(lat), 16'd4);
    chk({tag, "_data"}, {11'd0, out_data}, {11'd0, exp});
    $display("xact %s in=0x%03h out=0x%02h exp=0x%02h lat=%0d", tag, d, out_data, exp, lat);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef GF_ACC_EN
    acc_clr   = 1'b1;  // keep acc at zero for the plain-reduction vectors
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_out_data", {11'd0, out_data}, 16'd0);
    chk("reset_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {15'd0, in_ready}, 16'd1);

    // Basic reductions
    xact("v155", 9'h155, 5'h12);
    xact("v020", 9'h020, 5'h05);
    xact("v100", 9'h100, 5'h0D);
    xact("v1FF", 9'h1FF, 5'h09);
    xact("v01F", 9'h01F, 5'h1F);

    // Output stall for 10 cycles
    out_ready = 1'b0;
    send(9'h155);
    wait_out(lat);
    chk("stall_latency", 16'(lat), 16'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {15'd0, out_valid}, 16'd1);
      chk("stall_data", {11'd0, out_data}, 16'h12);
      chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
    end
    $display("xact stall in=0x155 out=0x%02h held 10 cycles", out_data);
    // Release with a new product offered in the same cycle
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'h020;
    #1;
    chk("handoff_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("handoff_valid_drop", {15'd0, out_valid}, 16'd0);
    wait_out(lat);
    chk("handoff_latency", 16'(lat), 16'd4);
    chk("handoff_data", {11'd0, out_data}, 16'h05);
    $display("xact handoff in=0x020 out=0x%02h exp=0x05 lat=%0d", out_data, lat);
    @(posedge clk);
    #1;
    chk("handoff_done_drop", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset in the middle of RED
    send(9'h1FF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midreset_in_ready", {15'd0, in_ready}, 16'd1);
    chk("midreset_out_data", {11'd0, out_data}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("midreset_no_output", {15'd0, out_valid}, 16'd0);
    end
    $display("xact midreset aborted in=0x1FF, no output");
    xact("after_reset", 9'h100, 5'h0D);

`ifdef GF_ACC_EN
    // Accumulator sequence
    @(negedge clk);
    acc_clr = 1'b0;
    xact("acc_020", 9'h020, 5'h05);
    xact("acc_100", 9'h100, 5'h08);
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    xact("acc_clr_155", 9'h155, 5'h12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
